// File: rtl/dcache_sram_arb.sv
// Shared dcache SRAM port arbiter: port 0 fixed priority, ports 1..NR_PORTS-1 round-robin,
// starvation guard on port 0, registered read-valid routing. Optional perf counter: DCACHE_ARB_PERF_EN.
module dcache_sram_arb #(
  parameter int unsigned NR_PORTS     = 4,
  parameter int unsigned WAYS         = 8,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NR_PORTS-1:0][WAYS-1:0]           req_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [NR_PORTS-1:0]                     we_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]   be_i,
  output logic [NR_PORTS-1:0]                     gnt_o,
  output logic [NR_PORTS-1:0]                     rvalid_o,
  output logic [WAYS-1:0]                         sram_req_o,
  output logic [ADDR_WIDTH-1:0]                   sram_addr_o,
  output logic                                    sram_we_o,
  output logic [DATA_WIDTH-1:0]                   sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                 sram_be_o,
  output logic [31:0]                             conflict_cnt_o
);

  localparam int unsigned PTR_W      = $clog2(NR_PORTS);
  localparam logic [7:0]  STARVE_MAX = 8'(STARVE_LIMIT);

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]          starve_cnt_q, starve_cnt_d;
  logic [NR_PORTS-1:0] rvalid_q, rvalid_d;
  logic [NR_PORTS-1:0] port_req;
  logic [NR_PORTS-1:0] gnt;
  logic                any_rr;
  logic                rr_found;
  logic [PTR_W-1:0]    rr_idx;
  logic                win_vld;
  logic [PTR_W-1:0]    win_idx;
  int unsigned         scan_idx;

  always_comb begin
    port_req = '0;
    for (int p = 0; p < NR_PORTS; p++) port_req[p] = |req_i[p];
    any_rr = |port_req[NR_PORTS-1:1];

    // Round-robin scan over ports 1..NR_PORTS-1 starting at rr_ptr_q.
    rr_found = 1'b0;
    rr_idx   = '0;
    scan_idx = 0;
    for (int i = 0; i < NR_PORTS - 1; i++) begin
      scan_idx = ((int'(rr_ptr_q) - 1 + i) % (NR_PORTS - 1)) + 1;
      if (!rr_found && port_req[PTR_W'(scan_idx)]) begin
        rr_found = 1'b1;
        rr_idx   = PTR_W'(scan_idx);
      end
    end

    win_vld = 1'b0;
    win_idx = '0;
    if (rst_i) begin
      win_vld = 1'b0;
    end else if (port_req[0] && (starve_cnt_q < STARVE_MAX)) begin
      win_vld = 1'b1;
    end else if (rr_found) begin
      win_vld = 1'b1;
      win_idx = rr_idx;
    end else if (port_req[0]) begin
      win_vld = 1'b1;
    end

    gnt = '0;
    if (win_vld) gnt[win_idx] = 1'b1;

    sram_req_o   = '0;
    sram_addr_o  = '0;
    sram_we_o    = 1'b0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (win_vld) begin
      sram_req_o   = req_i[win_idx];
      sram_addr_o  = addr_i[win_idx];
      sram_we_o    = we_i[win_idx];
      sram_wdata_o = wdata_i[win_idx];
      sram_be_o    = be_i[win_idx];
    end

    rr_ptr_d = rr_ptr_q;
    if (win_vld && (win_idx != '0)) begin
      rr_ptr_d = (win_idx == PTR_W'(NR_PORTS - 1)) ? PTR_W'(1) : win_idx + PTR_W'(1);
    end

    // Counts port-0 wins only while the RR group is waiting; anything else clears it.
    starve_cnt_d = 8'd0;
    if (gnt[0] && any_rr) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end

    rvalid_d = gnt & ~we_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q     <= PTR_W'(1);
      starve_cnt_q <= 8'd0;
      rvalid_q     <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (($countones(port_req) >= 2) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) conflict_cnt_q <= 32'd0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = 32'h0;
`endif

endmodule
